product_sched: RTL

PRODUCT_SCHED -- requirements
Module: product_sched

---
 rtl/product_sched.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/product_sched.sv
// Product-unit issue scheduler: splits each row descriptor into beats of
// PARALLELISM lanes, gates issue on operand availability and downstream
// credits, and carries the beat sideband alongside the fixed-latency product
// unit so that out_* lines up with prod_valid.
module product_sched #(
  parameter int PARALLELISM = 4,
  parameter int DELAY       = 2,
  parameter int LEN_WIDTH   = 16,
  parameter int CREDITS     = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   row_valid,
  output logic                   row_ready,
  input  logic [LEN_WIDTH-1:0]   row_len,
  input  logic                   data_valid,
  output logic                   data_ready,
  output logic                   issue_valid,
  output logic [PARALLELISM-1:0] issue_mask,
  output logic                   issue_last,
  input  logic                   prod_valid,
  output logic                   out_valid,
  output logic                   out_last,
  output logic [PARALLELISM-1:0] out_mask,
  input  logic                   credit_return,
  output logic                   busy,
  output logic                   err
);

  localparam int CW = $clog2(CREDITS + 1);
  localparam int GW = $clog2(DELAY + 1);

  localparam logic [LEN_WIDTH-1:0] PAR_LEN    = LEN_WIDTH'(PARALLELISM);
  localparam logic [CW-1:0]        CREDIT_MAX = CW'(CREDITS);
  localparam logic [CW-1:0]        CREDIT_ONE = CW'(1);
  localparam logic [GW-1:0]        GUARD_INIT = GW'(DELAY);
  localparam logic [GW-1:0]        GUARD_ONE  = GW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ZERO  = 2'd2
  } state_t;

  state_t                          state;
  state_t                          state_next;
  logic [LEN_WIDTH-1:0]            remaining;
  logic [LEN_WIDTH-1:0]            remaining_next;
  logic [CW-1:0]                   credit_cnt;
  logic                            credit_ok;
  logic                            credit_take;
  logic                            credit_give;
  logic                            row_accept;
  logic [DELAY-1:0]                sb_valid;
  logic [DELAY-1:0]                sb_last;
  logic [DELAY-1:0][PARALLELISM-1:0] sb_mask;
  logic [GW-1:0]                   guard_cnt;

  assign row_ready  = (state == IDLE);
  assign row_accept = row_valid && row_ready;
  assign credit_ok  = (credit_cnt != '0);

  // Next state, beat handshake and live-lane mask for the beat on offer.
  always_comb begin
    // NOTE: every output of this block gets a default before the case so no
    // path leaves a value unassigned, which would infer a latch.
    state_next     = state;
    remaining_next = remaining;
    issue_valid    = 1'b0;
    issue_mask     = '0;
    issue_last     = 1'b0;
    data_ready     = 1'b0;
    unique case (state)
      IDLE: begin
        if (row_accept) begin
          if (row_len == '0) begin
            state_next = ZERO;
          end else begin
            state_next     = ISSUE;
            remaining_next = row_len;
          end
        end
      end
      ISSUE: begin
        issue_valid = data_valid && credit_ok;
        data_ready  = issue_valid;
        // Lane i is live while more than i elements of the row remain.
        for (int i = 0; i < PARALLELISM; i++) begin
          issue_mask[i] = (remaining > LEN_WIDTH'(i));
        end
        issue_last = (remaining <= PAR_LEN);
        if (issue_valid) begin
          if (issue_last) begin
            remaining_next = '0;
            state_next     = IDLE;
          end else begin
            remaining_next = remaining - PAR_LEN;
          end
        end
      end
      ZERO: begin
        // An empty row still emits one maskless closing beat, without
        // consuming operands.
        issue_valid = credit_ok;
        issue_last  = 1'b1;
        if (credit_ok) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and remaining-element count; reset abandons any row in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) begin
      state     <= IDLE;
      remaining <= '0;
    end else begin
      state     <= state_next;
      remaining <= remaining_next;
    end
  end

  // A return while already holding every credit has nothing to give back.
  assign credit_take = issue_valid;
  assign credit_give = credit_return && (credit_cnt != CREDIT_MAX);

  // Credit counter: one credit per issued beat, one back per consumed beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_cnt <= CREDIT_MAX;
    end else if (credit_take && !credit_give) begin
      credit_cnt <= credit_cnt - CREDIT_ONE;
    end else if (credit_give && !credit_take) begin
      credit_cnt <= credit_cnt + CREDIT_ONE;
    end
  end

  // Sideband delay line matching the product-unit latency.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: this chain is reset (unlike the product datapath) because
    // out_valid and busy must read 0 straight out of reset.
    if (!rst_n) begin
      sb_valid <= '0;
      sb_mask  <= '0;
      sb_last  <= '0;
    end else begin
      sb_valid[0] <= issue_valid;
      sb_mask[0]  <= issue_mask;
      sb_last[0]  <= issue_last;
      for (int k = 1; k < DELAY; k++) begin
        sb_valid[k] <= sb_valid[k-1];
        sb_mask[k]  <= sb_mask[k-1];
        sb_last[k]  <= sb_last[k-1];
      end
    end
  end

  assign out_valid = sb_valid[DELAY-1];
  assign out_mask  = sb_mask[DELAY-1];
  assign out_last  = sb_last[DELAY-1];

  // Sticky misalignment flag; the guard hides the un-reset product pipeline
  // draining stale beats for DELAY cycles after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      guard_cnt <= GUARD_INIT;
      err       <= 1'b0;
    end else if (guard_cnt != '0) begin
      guard_cnt <= guard_cnt - GUARD_ONE;
    end else if (prod_valid != out_valid) begin
      err <= 1'b1;
    end
  end

  assign busy = (state != IDLE) || (|sb_valid);

endmodule
